// File: rtl/mem_responder_pkg.sv
// Shared definitions for the handshaked memory responder.
//   ST_IDLE / ST_RESP : encodings of the two FSM states; the bench imports them too
//   WORD_BYTES        : bytes per stored word
//   state_e           : FSM state type built on those encodings
//   merge_bytes       : byte-strobed merge of new data into an existing word
package mem_responder_pkg;

  localparam logic ST_IDLE    = 1'b0;
  localparam logic ST_RESP    = 1'b1;
  localparam int   WORD_BYTES = 4;

  typedef enum logic {
    IDLE = ST_IDLE,
    RESP = ST_RESP
  } state_e;

  // Replace each byte lane of old_word whose strobe bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/word_ram.sv
// Word array with synchronous byte-strobed write and a registered read port.
//   clk   : clock
//   reset : synchronous active-high; clears only the read register
//   idx   : word index shared by the write and read operations
//   we    : write enable; wstrb selects the byte lanes taken from wdata
//   re    : load array[idx] into the read register
//   clr   : zero the read register (re takes priority)
//   rdata : read register output, holds until re, clr or reset
module word_ram
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  localparam int         AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] idx,
  input  logic          we,
  input  logic [3:0]    wstrb,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic          clr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q, rdata_d;

  // NOTE: the array has no reset branch; clearing every word would force it
  // out of RAM macros into flops, and stored data must survive reset anyway.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= merge_bytes(mem[idx], wdata, wstrb);
  end

  // NOTE: the hold assignment comes first so every path assigns rdata_d and
  // no latch is inferred.
  always_comb begin
    rdata_d = rdata_q;
    if (clr) rdata_d = '0;
    if (re)  rdata_d = mem[idx];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Handshaked data-memory responder: accepts one load or store per transaction
// on a valid/ready request channel and answers on a valid/ready response channel.
//   clk, reset                        : clock, synchronous active-high reset
//   req_valid/req_ready               : request handshake (req_ready decodes state only)
//   req_write, req_addr               : 1 = store; byte address
//   req_wdata, req_wstrb              : store data and byte enables
//   resp_valid/resp_ready             : response handshake
//   resp_rdata, resp_err              : load data (0 for stores/errors); address error
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * WORD_BYTES);

  state_e        state_q, state_d;
  logic          resp_err_q, resp_err_d;
  logic          accept;
  logic [31:0]   off;
  logic          addr_err;
  logic [AW-1:0] idx;

  assign accept = (state_q == IDLE) && req_valid;

  // Out-of-range addresses are rejected outright rather than aliased.
  assign off      = req_addr - BASE_ADDR;
  assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) ||
                    (off >= SPAN_BYTES);
  assign idx      = off[2 +: AW];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      resp_err_q <= resp_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    resp_err_d = resp_err_q;
    unique case (state_q)
      IDLE: if (req_valid) begin
        state_d    = RESP;
        resp_err_d = addr_err;
      end
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: no combinational path from inputs to req_ready.
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
  end

  assign resp_err = resp_err_q;

  // Write and read are suppressed on a reset edge so a coinciding accept has
  // no side effect; clr zeroes the response for stores and errored requests.
  word_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_word_ram (
    .clk   (clk),
    .reset (reset),
    .idx   (idx),
    .we    (accept && req_write && !addr_err && !reset),
    .wstrb (req_wstrb),
    .wdata (req_wdata),
    .re    (accept && !req_write && !addr_err && !reset),
    .clr   (accept),
    .rdata (resp_rdata)
  );

endmodule
